fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 1, word-addressed PC increment per fetched instruction.
REQ-003 Parameter TIMEOUT, default 15, max cycles waiting for imem_ack before error.
REQ-004 Clk  in  1  single clock; all state changes on rising edge.
REQ-005 Rst  in  1  asynchronous, active-low reset.
REQ-006 dec_ready  in  1  decode accepts inst this cycle.
REQ-007 redirect  in  1  branch/jump taken; load redirect_pc.
REQ-008 redirect_pc  in  32  redirect target address.
REQ-009 imem_ack  in  1  instruction memory returns data this cycle.
REQ-010 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-011 imem_req  out  1  one-cycle fetch request pulse.
REQ-012 imem_addr  out  32  fetch address, valid when imem_req=1.
REQ-013 inst_valid  out  1  inst/inst_pc hold a valid instruction for decode.
REQ-014 inst  out  32  fetched instruction word.
REQ-015 inst_pc  out  32  address of inst.
REQ-016 pc  out  32  address of next fetch.
REQ-017 fetch_err  out  1  sticky memory-timeout flag.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, DRAIN, ERR; exactly one outstanding request at any time.
REQ-019 IDLE: no outputs asserted; SHALL go to REQ next cycle.
REQ-020 REQ: imem_req=1 and imem_addr=pc for exactly one cycle; SHALL go to WAIT.
REQ-021 WAIT: on imem_ack, SHALL register inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+PC_STEP (mod 2^32, wrap from 32'hFFFF_FFFF silent), go to HOLD.
REQ-022 HOLD: inst_valid=1, inst/inst_pc stable; on dec_ready=1 the handshake completes, inst_valid<=0, go to REQ.
REQ-023 Redirect priority: redirect=1 SHALL override every other event in the same cycle; pc<=redirect_pc, inst_valid<=0.
REQ-024 Redirect in IDLE or HOLD (including HOLD with dec_ready=1) -> REQ; the held instruction is dropped, not handed off.
REQ-025 Redirect in REQ (request already issued) or in WAIT without imem_ack -> DRAIN.
REQ-026 Redirect in WAIT with imem_ack the same cycle -> returned data discarded, go to REQ.
REQ-027 DRAIN: imem_req=0, inst_valid=0; on imem_ack discard data, go to REQ; further redirect in DRAIN only updates pc.
REQ-028 A 4-bit-or-wider wait counter SHALL clear on entry to WAIT/DRAIN and increment each cycle without imem_ack; reaching TIMEOUT SHALL go to ERR.
REQ-029 ERR: fetch_err=1, imem_req=0, inst_valid=0; state held, redirect ignored, until reset.
REQ-030 imem_ack outside WAIT/DRAIN SHALL be ignored.
REQ-031 Throughput: with 1-cycle ack and dec_ready held 1, one instruction per 3 cycles (REQ, WAIT, HOLD).

Reset
REQ-032 Rst=0 SHALL asynchronously force state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, imem_req=0, imem_addr=0, fetch_err=0, wait counter=0.
REQ-033 Reset mid-request SHALL abandon the outstanding request; a late imem_ack after release is ignored per REQ-030.
REQ-034 First imem_req SHALL occur on the second rising edge after Rst deasserts.

Verification
REQ-035 Reset release, ack 1 cycle after each req, dec_ready=1 -> imem_addr sequence 0,1,2,3; inst_pc matches; inst_valid 1 cycle in every 3.
REQ-036 dec_ready=0 for 5 cycles in HOLD at inst_pc=2 -> inst/inst_pc stable, no imem_req, then fetch of 3 after dec_ready=1.
REQ-037 Redirect to 32'h40 in WAIT, ack 2 cycles later with data 32'hDEAD_BEEF -> inst_valid never 1 for that data, next imem_addr=32'h40.
REQ-038 Redirect to 32'h80 in same cycle as ack -> data dropped, next cycle REQ with imem_addr=32'h80.
REQ-039 No ack for 15 cycles after req -> fetch_err=1, imem_req stays 0; Rst pulse -> fetch_err=0, pc=RESET_PC.
REQ-040 Redirect to 32'hFFFF_FFFF, ack -> pc wraps to 32'h0000_0000, next imem_addr=0.

Source files
------------

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - single-outstanding instruction fetch controller
// Issues one imem request at a time, holds the fetched word for decode, handles redirects and timeouts.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 1,
  parameter int          TIMEOUT  = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dec_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic [31:0] o_pc,
  output logic        o_fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_ERR
  } state_t;

  localparam logic [7:0]  TIMEOUT_W = 8'(TIMEOUT);
  localparam logic [31:0] STEP_W    = 32'(PC_STEP);

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_inst, r_inst_pc;
  logic        r_inst_valid, w_valid_next;
  logic        w_inst_load;
  logic [7:0]  r_wait_cnt, w_cnt_next;
  logic [7:0]  w_cnt_inc;
  logic        r_fetch_err, w_err_next;

  assign w_cnt_inc = r_wait_cnt + 8'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_inst_valid <= 1'b0;
      r_wait_cnt   <= 8'h0;
      r_fetch_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_inst_valid <= w_valid_next;
      r_wait_cnt   <= w_cnt_next;
      r_fetch_err  <= w_err_next;
      if (w_inst_load) begin
        r_inst    <= i_imem_rdata;
        r_inst_pc <= r_pc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_valid_next = r_inst_valid;
    w_inst_load  = 1'b0;
    w_cnt_next   = r_wait_cnt;
    w_err_next   = r_fetch_err;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_REQ;
        if (i_redirect) w_pc_next = i_redirect_pc;
      end
      S_REQ: begin
        w_cnt_next = 8'h0;
        if (i_redirect) begin
          w_pc_next    = i_redirect_pc;
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_redirect) begin
          // An ack in the same cycle retires the request, so no drain is needed.
          w_pc_next    = i_redirect_pc;
          w_valid_next = 1'b0;
          w_cnt_next   = 8'h0;
          w_state_next = i_imem_ack ? S_REQ : S_DRAIN;
        end else if (i_imem_ack) begin
          w_inst_load  = 1'b1;
          w_valid_next = 1'b1;
          w_pc_next    = r_pc + STEP_W;
          w_state_next = S_HOLD;
        end else if (w_cnt_inc == TIMEOUT_W) begin
          w_cnt_next   = w_cnt_inc;
          w_err_next   = 1'b1;
          w_state_next = S_ERR;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          w_pc_next    = i_redirect_pc;
          w_valid_next = 1'b0;
          w_state_next = S_REQ;
        end else if (i_dec_ready) begin
          w_valid_next = 1'b0;
          w_state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        w_valid_next = 1'b0;
        if (i_redirect) w_pc_next = i_redirect_pc;
        if (i_imem_ack) begin
          w_state_next = S_REQ;
        end else if (w_cnt_inc == TIMEOUT_W) begin
          w_cnt_next   = w_cnt_inc;
          w_err_next   = 1'b1;
          w_state_next = S_ERR;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_ERR: begin
        w_err_next   = 1'b1;
        w_valid_next = 1'b0;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_imem_req   = (r_state == S_REQ);
  assign o_imem_addr  = (r_state == S_REQ) ? r_pc : 32'h0;
  assign o_inst_valid = r_inst_valid;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_pc         = r_pc;
  assign o_fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller
// Vector table of fetches plus hand-written redirect, timeout and reset sequences.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_dec_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic [31:0] o_pc;
  logic        o_fetch_err;

  fetch_controller dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_dec_ready  (i_dec_ready),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .o_inst_valid (o_inst_valid),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc),
    .o_pc         (o_pc),
    .o_fetch_err  (o_fetch_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          ack_delay;
    int          stall;
  } vec_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc;
  int          last_req_cyc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name, input int exp_cycles);
    int n = 0;
    while (!o_imem_req && n < 20) begin
      tick();
      n++;
    end
    check32(name, 32'(n), 32'(exp_cycles));
  endtask

  task automatic pop_and_check();
    exp_t e;
    check1("inst_valid", o_inst_valid, 1'b1);
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_underflow: got inst %h with no expected entry", o_inst);
    end else begin
      e = sb_q.pop_front();
      check32("inst", o_inst, e.inst);
      check32("inst_pc", o_inst_pc, e.pc);
    end
  endtask

  // Entered with the DUT sampled in REQ; leaves it sampled in the following REQ.
  task automatic do_fetch(input logic [31:0] data, input int ack_delay, input int stall);
    logic [31:0] held_inst, held_pc;
    check1("req_pulse", o_imem_req, 1'b1);
    check32("req_addr", o_imem_addr, exp_pc);
    tick();
    check1("req_one_cycle", o_imem_req, 1'b0);
    for (int k = 0; k < ack_delay; k++) begin
      tick();
      check1("wait_no_valid", o_inst_valid, 1'b0);
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = data;
    sb_q.push_back('{data, exp_pc});
    tick();
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'h0;
    exp_pc       = exp_pc + 32'd1;
    check32("pc_after_ack", o_pc, exp_pc);
    held_inst = data;
    held_pc   = exp_pc - 32'd1;
    pop_and_check();
    for (int k = 0; k < stall; k++) begin
      i_imem_ack   = 1'b1;
      i_imem_rdata = $urandom;
      tick();
      check1("stall_valid", o_inst_valid, 1'b1);
      check32("stall_inst", o_inst, held_inst);
      check32("stall_inst_pc", o_inst_pc, held_pc);
      check1("stall_no_req", o_imem_req, 1'b0);
    end
    i_imem_ack  = 1'b0;
    i_dec_ready = 1'b1;
    tick();
    i_dec_ready = 1'b0;
    check1("valid_dropped", o_inst_valid, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'hA000_0000, 0, 0};
    vecs[1] = '{32'hA111_1111, 0, 0};
    vecs[2] = '{32'hA222_2222, 0, 5};
    vecs[3] = '{32'hA333_3333, 0, 0};
    vecs[4] = '{32'hA444_4444, 3, 1};
    vecs[5] = '{32'hA555_5555, 14, 0};

    i_rst_n       = 1'b0;
    i_dec_ready   = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_imem_ack    = 1'b0;
    i_imem_rdata  = 32'h0;
    exp_pc        = 32'h0;

    tick();
    tick();
    check1("rst_req", o_imem_req, 1'b0);
    check32("rst_addr", o_imem_addr, 32'h0);
    check1("rst_valid", o_inst_valid, 1'b0);
    check32("rst_inst", o_inst, 32'h0);
    check32("rst_inst_pc", o_inst_pc, 32'h0);
    check32("rst_pc", o_pc, 32'h0);
    check1("rst_err", o_fetch_err, 1'b0);

    i_rst_n = 1'b1;
    wait_req("first_req_latency", 1);

    for (int i = 0; i < 6; i++) begin
      if (i > 0 && vecs[i-1].ack_delay == 0 && vecs[i-1].stall == 0)
        check32("throughput", 32'(cyc - last_req_cyc), 32'd3);
      last_req_cyc = cyc;
      do_fetch(vecs[i].data, vecs[i].ack_delay, vecs[i].stall);
    end

    // Redirect while waiting; the late ack must be drained, not delivered.
    tick();
    i_redirect = 1'b1; i_redirect_pc = 32'h40;
    tick();
    i_redirect = 1'b0;
    check1("drain_no_valid0", o_inst_valid, 1'b0);
    tick();
    check1("drain_no_req", o_imem_req, 1'b0);
    i_imem_ack = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_ack = 1'b0;
    check1("drain_no_valid1", o_inst_valid, 1'b0);
    exp_pc = 32'h40;
    do_fetch(32'hB040_0000, 0, 0);

    // Redirect coincident with ack: data discarded, immediate REQ.
    tick();
    i_imem_ack = 1'b1; i_imem_rdata = 32'h1234_5678;
    i_redirect = 1'b1; i_redirect_pc = 32'h80;
    tick();
    i_imem_ack = 1'b0; i_redirect = 1'b0;
    check1("ackredir_no_valid", o_inst_valid, 1'b0);
    exp_pc = 32'h80;
    check1("ackredir_req", o_imem_req, 1'b1);
    check32("ackredir_addr", o_imem_addr, 32'h80);

    // Redirect in HOLD with dec_ready also high: held word dropped.
    tick();
    i_imem_ack = 1'b1; i_imem_rdata = 32'hC080_0000;
    sb_q.push_back('{32'hC080_0000, 32'h80});
    tick();
    i_imem_ack = 1'b0;
    pop_and_check();
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFF; i_dec_ready = 1'b1;
    tick();
    i_redirect = 1'b0; i_dec_ready = 1'b0;
    check1("holdredir_valid", o_inst_valid, 1'b0);
    exp_pc = 32'hFFFF_FFFF;
    do_fetch(32'hDFFF_FFFF, 0, 0);
    check32("wrap_addr", o_imem_addr, 32'h0);
    do_fetch(32'hE000_0000, 0, 0);

    // Redirect in REQ then again in DRAIN: last target wins.
    i_redirect = 1'b1; i_redirect_pc = 32'h100;
    tick();
    i_redirect_pc = 32'h200;
    tick();
    i_redirect = 1'b0;
    i_imem_ack = 1'b1;
    tick();
    i_imem_ack = 1'b0;
    exp_pc = 32'h200;
    check32("drain_redir_addr", o_imem_addr, 32'h200);

    // Timeout: no ack for TIMEOUT wait cycles.
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      check1("timeout_err", o_fetch_err, (i == 15));
    end
    i_redirect = 1'b1; i_redirect_pc = 32'h999; i_imem_ack = 1'b1;
    repeat (3) tick();
    i_redirect = 1'b0; i_imem_ack = 1'b0;
    check1("err_sticky", o_fetch_err, 1'b1);
    check1("err_no_req", o_imem_req, 1'b0);
    check32("err_pc_held", o_pc, 32'h200);

    #2 i_rst_n = 1'b0;
    #1;
    check1("async_rst_err", o_fetch_err, 1'b0);
    check32("async_rst_pc", o_pc, 32'h0);
    tick();
    i_rst_n = 1'b1;
    exp_pc  = 32'h0;
    wait_req("rerelease_latency", 1);

    // Reset mid-request; a late ack in IDLE must be ignored.
    tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0BAD_0BAD;
    tick();
    i_imem_ack = 1'b0;
    check1("late_ack_valid", o_inst_valid, 1'b0);
    do_fetch(32'hF000_0000, 0, 0);

    check32("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
